// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants, tracker state type and hit() helper for hazard_ctrl
// Contents:
//   FWD_RF / FWD_WB / FWD_MEM  E-stage operand select codes
//   mdu_state_t                MDU tracker states
//   hit(x, y)                  register match, ignoring the zero register
package hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_t;

    // Widest register address hit() accepts; callers cast their AW-wide
    // addresses up to this width.
    localparam int HIT_W = 32;

    // Register 0 is hardwired to zero, so it never creates a dependence.
    function automatic logic hit(input logic [HIT_W-1:0] x, input logic [HIT_W-1:0] y);
        return (x != '0) && (x == y);
    endfunction

endpackage

// File: rtl/mdu_tracker.sv
// rtl/mdu_tracker.sv - tracks one outstanding multi-cycle MDU operation
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      MDU op issuing from E this cycle (ignored while BUSY)
//   dst_in     destination register of the issuing op
//   busy       tracker not IDLE (BUSY or DONE)
//   done       one-cycle pulse in the cycle the MDU result is written
//   dst        captured destination register
module mdu_tracker
    import hazard_pkg::*;
#(
    parameter int AW      = 5,
    parameter int MDU_LAT = 4,
    parameter int CW      = $clog2(MDU_LAT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] dst_in,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] dst
);

    // BUSY lasts MDU_LAT-1 cycles (cnt counts MDU_LAT-2 down to 0) and DONE
    // is the final cycle, so done lands exactly MDU_LAT cycles after issue.
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 2);

    mdu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] dst_q, dst_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dst_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dst_q   <= dst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dst_d   = dst_q;
        case (state_q)
            IDLE, DONE: begin
                // A new op may issue in the DONE cycle: back-to-back MDU ops.
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = CNT_LOAD;
                    dst_d   = dst_in;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign dst  = dst_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall, flush and forwarding control for the 5-stage pipeline
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rsD, rtD / rsE, rtE           source registers in D / E
//   wrE, wrM, wrW                 destination registers in E / M / W
//   regwrE, regwrM, regwrW        register-write enables in E / M / W
//   memtoregE, memtoregM          load in E / M
//   branchD, mduD                 branch / MDU op in D
//   mdu_startE                    MDU op issuing from E this cycle
//   stallF, stallD, flushE        hold PC, hold IF/ID, bubble ID/EX
//   fwdAD, fwdBD                  forward ALUOutM into the D comparator
//   fwdAE, fwdBE                  E operand select (RF / ResultW / ALUOutM)
//   mdu_busy, mdu_done, mdu_dst   MDU tracker status
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int AW      = 5,
    parameter int MDU_LAT = 4,
    parameter int CW      = $clog2(MDU_LAT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rsD,
    input  logic [AW-1:0] rtD,
    input  logic [AW-1:0] rsE,
    input  logic [AW-1:0] rtE,
    input  logic [AW-1:0] wrE,
    input  logic [AW-1:0] wrM,
    input  logic [AW-1:0] wrW,
    input  logic          regwrE,
    input  logic          regwrM,
    input  logic          regwrW,
    input  logic          memtoregE,
    input  logic          memtoregM,
    input  logic          branchD,
    input  logic          mduD,
    input  logic          mdu_startE,
    output logic          stallF,
    output logic          stallD,
    output logic          flushE,
    output logic          fwdAD,
    output logic          fwdBD,
    output logic [1:0]    fwdAE,
    output logic [1:0]    fwdBE,
    output logic          mdu_busy,
    output logic          mdu_done,
    output logic [AW-1:0] mdu_dst
);

    function automatic logic hit_aw(input logic [AW-1:0] x, input logic [AW-1:0] y);
        return hit(HIT_W'(x), HIT_W'(y));
    endfunction

    logic lwstall, brstall, mdustall, stall;

    mdu_tracker #(
        .AW      (AW),
        .MDU_LAT (MDU_LAT),
        .CW      (CW)
    ) u_mdu_tracker (
        .clk    (clk),
        .rst    (rst),
        .start  (mdu_startE),
        .dst_in (wrE),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .dst    (mdu_dst)
    );

    // Load in E: its data is not available until W, too late for D or E.
    assign lwstall = memtoregE & regwrE & (hit_aw(rsD, wrE) | hit_aw(rtD, wrE));

    // The branch comparator sits in D, so it cannot take ALU results still
    // in E, nor load data still in M.
    assign brstall = branchD &
                     ((regwrE    & (hit_aw(rsD, wrE) | hit_aw(rtD, wrE))) |
                      (memtoregM & (hit_aw(rsD, wrM) | hit_aw(rtD, wrM))));

    // Busy includes DONE, so a dependent read waits until after the write
    // cycle. mduD is a structural stall: only one MDU op may be in flight.
    assign mdustall = mdu_busy & (hit_aw(rsD, mdu_dst) | hit_aw(rtD, mdu_dst) | mduD);

    assign stall  = lwstall | brstall | mdustall;
    assign stallF = stall;
    assign stallD = stall;
    assign flushE = stall;

    assign fwdAD = regwrM & hit_aw(rsD, wrM);
    assign fwdBD = regwrM & hit_aw(rtD, wrM);

    // M is the younger producer, so it wins over W.
    always_comb begin
        fwdAE = FWD_RF;
        if (regwrM && hit_aw(rsE, wrM)) begin
            fwdAE = FWD_MEM;
        end else if (regwrW && hit_aw(rsE, wrW)) begin
            fwdAE = FWD_WB;
        end
    end

    always_comb begin
        fwdBE = FWD_RF;
        if (regwrM && hit_aw(rtE, wrM)) begin
            fwdBE = FWD_MEM;
        end else if (regwrW && hit_aw(rtE, wrW)) begin
            fwdBE = FWD_WB;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int AW  = 5;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic          regwrE, regwrM, regwrW, memtoregE, memtoregM, branchD, mduD, mdu_startE;
    logic          stallF, stallD, flushE, fwdAD, fwdBD, mdu_busy, mdu_done;
    logic [1:0]    fwdAE, fwdBE;
    logic [AW-1:0] mdu_dst;

    always #5 clk = ~clk;

    hazard_ctrl #(.AW(AW), .MDU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .wrE(wrE), .wrM(wrM), .wrW(wrW),
        .regwrE(regwrE), .regwrM(regwrM), .regwrW(regwrW),
        .memtoregE(memtoregE), .memtoregM(memtoregM),
        .branchD(branchD), .mduD(mduD), .mdu_startE(mdu_startE),
        .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .fwdAD(fwdAD), .fwdBD(fwdBD), .fwdAE(fwdAE), .fwdBE(fwdBE),
        .mdu_busy(mdu_busy), .mdu_done(mdu_done), .mdu_dst(mdu_dst)
    );

    typedef struct {
        logic          rst;
        logic [AW-1:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
        logic          regwrE, regwrM, regwrW, memtoregE, memtoregM, branchD, mduD, mdu_startE;
    } in_t;

    typedef struct {
        logic          stall, fad, fbd;
        logic [1:0]    fae, fbe;
        logic          busy, done;
        logic [AW-1:0] dst;
    } exp_t;

    exp_t          sb[$];
    int            n_chk  = 0;
    int            n_pass = 0;
    in_t           a;               // inputs currently applied
    int            cur    = 0;      // index of the cycle being driven
    int            st     = -1;     // cycle of the last accepted MDU issue, -1 none
    logic [AW-1:0] mdst   = '0;

    // Reference: an MDU issued in cycle s occupies cycles s+1..s+LAT, done at s+LAT.
    function automatic bit m_busy();
        return (st >= 0) && (cur - st >= 1) && (cur - st <= LAT);
    endfunction

    function automatic bit m_done();
        return (st >= 0) && (cur - st == LAT);
    endfunction

    function automatic bit h(input logic [AW-1:0] x, input logic [AW-1:0] y);
        return (x != 0) && (x == y);
    endfunction

    function automatic logic [1:0] fsel(input logic [AW-1:0] r, input in_t v);
        if (v.regwrM && h(r, v.wrM)) return 2'd2;
        if (v.regwrW && h(r, v.wrW)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic exp_t model(input in_t v);
        exp_t e;
        bit lw, br, md;
        lw = v.memtoregE && v.regwrE && (h(v.rsD, v.wrE) || h(v.rtD, v.wrE));
        br = v.branchD && ((v.regwrE && (h(v.rsD, v.wrE) || h(v.rtD, v.wrE))) ||
                           (v.memtoregM && (h(v.rsD, v.wrM) || h(v.rtD, v.wrM))));
        md = m_busy() && (h(v.rsD, mdst) || h(v.rtD, mdst) || v.mduD);
        e.stall = lw || br || md;
        e.fad   = v.regwrM && h(v.rsD, v.wrM);
        e.fbd   = v.regwrM && h(v.rtD, v.wrM);
        e.fae   = fsel(v.rsE, v);
        e.fbe   = fsel(v.rtE, v);
        e.busy  = m_busy();
        e.done  = m_done();
        e.dst   = mdst;
        return e;
    endfunction

    function automatic in_t zero_in();
        in_t v;
        v.rst = 0; v.rsD = 0; v.rtD = 0; v.rsE = 0; v.rtE = 0;
        v.wrE = 0; v.wrM = 0; v.wrW = 0;
        v.regwrE = 0; v.regwrM = 0; v.regwrW = 0; v.memtoregE = 0; v.memtoregM = 0;
        v.branchD = 0; v.mduD = 0; v.mdu_startE = 0;
        return v;
    endfunction

    task automatic apply(input in_t v);
        rst = v.rst; rsD = v.rsD; rtD = v.rtD; rsE = v.rsE; rtE = v.rtE;
        wrE = v.wrE; wrM = v.wrM; wrW = v.wrW;
        regwrE = v.regwrE; regwrM = v.regwrM; regwrW = v.regwrW;
        memtoregE = v.memtoregE; memtoregM = v.memtoregM;
        branchD = v.branchD; mduD = v.mduD; mdu_startE = v.mdu_startE;
        a = v;
    endtask

    // Advance the reference over the edge, then drive the next cycle and
    // queue what the DUT must show in it.
    task automatic step(input in_t v);
        @(posedge clk);
        if (a.rst) begin
            st   = -1;
            mdst = '0;
        end else if (a.mdu_startE) begin
            st   = cur;
            mdst = a.wrE;
        end
        cur++;
        #1;
        if (v.mdu_startE && m_busy() && !m_done()) v.mdu_startE = 1'b0;
        apply(v);
        sb.push_back(model(v));
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cur);
    endtask

    // Monitor: pops one expectation per driven cycle and compares mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_stallF",   32'(stallF),   32'(e.stall));
                check("sb_stallD",   32'(stallD),   32'(e.stall));
                check("sb_flushE",   32'(flushE),   32'(e.stall));
                check("sb_fwdAD",    32'(fwdAD),    32'(e.fad));
                check("sb_fwdBD",    32'(fwdBD),    32'(e.fbd));
                check("sb_fwdAE",    32'(fwdAE),    32'(e.fae));
                check("sb_fwdBE",    32'(fwdBE),    32'(e.fbe));
                check("sb_mdu_busy", 32'(mdu_busy), 32'(e.busy));
                check("sb_mdu_done", 32'(mdu_done), 32'(e.done));
                check("sb_mdu_dst",  32'(mdu_dst),  32'(e.dst));
                check("start_not_in_busy", 32'(mdu_startE & mdu_busy & ~mdu_done), 32'd0);
            end
        end
    end

    task automatic mdu_window(input bit use_mdud);
        in_t v;
        v = zero_in();
        v.mdu_startE = 1; v.wrE = 9;
        if (use_mdud) v.mduD = 1; else v.rsD = 9;
        step(v);
        @(negedge clk);
        check("mdu_issue_stall", 32'(stallD), 32'd0);
        v.mdu_startE = 0; v.wrE = 0;
        for (int k = 1; k <= 5; k++) begin
            step(v);
            @(negedge clk);
            check($sformatf("mdu%0d_stall_t%0d", use_mdud, k), 32'(stallD), 32'(k <= 4));
            check($sformatf("mdu%0d_done_t%0d", use_mdud, k), 32'(mdu_done), 32'(k == 4));
        end
    endtask

    initial begin
        in_t v;
        v = zero_in();
        v.rst = 1;
        apply(v);
        step(v);
        step(v);
        v.rst = 0;
        step(v);
        @(negedge clk);
        check("reset_busy", 32'(mdu_busy), 32'd0);
        check("reset_done", 32'(mdu_done), 32'd0);
        check("reset_dst",  32'(mdu_dst),  32'd0);

        v = zero_in(); v.memtoregE = 1; v.regwrE = 1; v.wrE = 8; v.rsD = 8;
        step(v); @(negedge clk);
        check("lu_stallF", 32'(stallF), 32'd1);
        check("lu_stallD", 32'(stallD), 32'd1);
        check("lu_flushE", 32'(flushE), 32'd1);
        v.wrE = 0; v.rsD = 0;
        step(v); @(negedge clk);
        check("lu_r0_stall", 32'(stallF), 32'd0);

        v = zero_in(); v.branchD = 1; v.memtoregM = 1; v.wrM = 3; v.rtD = 3;
        step(v); @(negedge clk);
        check("br_load_stall", 32'(stallD), 32'd1);
        check("br_load_fwdBD", 32'(fwdBD),  32'd0);
        v.memtoregM = 0; v.regwrM = 1;
        step(v); @(negedge clk);
        check("br_alu_stall", 32'(stallD), 32'd0);
        check("br_alu_fwdBD", 32'(fwdBD),  32'd1);

        v = zero_in(); v.rsE = 5; v.wrM = 5; v.wrW = 5; v.regwrM = 1; v.regwrW = 1;
        step(v); @(negedge clk);
        check("fwd_mem_prio", 32'(fwdAE), 32'd2);
        v.regwrM = 0;
        step(v); @(negedge clk);
        check("fwd_wb", 32'(fwdAE), 32'd1);
        v.rsE = 0;
        step(v); @(negedge clk);
        check("fwd_r0", 32'(fwdAE), 32'd0);

        mdu_window(1'b0);
        mdu_window(1'b1);

        // Back-to-back: second issue in the DONE cycle of the first.
        v = zero_in(); v.mdu_startE = 1; v.wrE = 9;
        step(v);
        v = zero_in();
        for (int k = 1; k <= 3; k++) step(v);
        v.mdu_startE = 1; v.wrE = 12;
        step(v); @(negedge clk);
        check("b2b_done1", 32'(mdu_done), 32'd1);
        check("b2b_dst1",  32'(mdu_dst),  32'd9);
        v = zero_in();
        for (int k = 1; k <= 4; k++) begin
            step(v); @(negedge clk);
            check($sformatf("b2b_busy_t%0d", k), 32'(mdu_busy), 32'd1);
            check($sformatf("b2b_dst_t%0d", k),  32'(mdu_dst),  32'd12);
            check($sformatf("b2b_done_t%0d", k), 32'(mdu_done), 32'(k == 4));
        end
        step(v);

        // Reset while BUSY aborts the op.
        v = zero_in(); v.mdu_startE = 1; v.wrE = 7;
        step(v);
        v = zero_in();
        step(v);
        v.rst = 1;
        step(v);
        v.rst = 0;
        step(v); @(negedge clk);
        check("rst_mid_busy", 32'(mdu_busy), 32'd0);
        check("rst_mid_done", 32'(mdu_done), 32'd0);
        check("rst_mid_dst",  32'(mdu_dst),  32'd0);
        for (int k = 1; k <= 4; k++) begin
            step(v); @(negedge clk);
            check($sformatf("rst_no_done_t%0d", k), 32'(mdu_done), 32'd0);
        end

        for (int i = 0; i < 600; i++) begin
            v.rst        = ($urandom_range(0, 79) == 0);
            v.rsD        = AW'($urandom_range(0, 7));
            v.rtD        = AW'($urandom_range(0, 7));
            v.rsE        = AW'($urandom_range(0, 7));
            v.rtE        = AW'($urandom_range(0, 7));
            v.wrE        = AW'($urandom_range(0, 7));
            v.wrM        = AW'($urandom_range(0, 7));
            v.wrW        = AW'($urandom_range(0, 7));
            v.regwrE     = 1'($urandom_range(0, 1));
            v.regwrM     = 1'($urandom_range(0, 1));
            v.regwrW     = 1'($urandom_range(0, 1));
            v.memtoregE  = 1'($urandom_range(0, 1));
            v.memtoregM  = 1'($urandom_range(0, 1));
            v.branchD    = 1'($urandom_range(0, 1));
            v.mduD       = ($urandom_range(0, 3) == 0);
            v.mdu_startE = ($urandom_range(0, 2) == 0);
            step(v);
        end

        v = zero_in();
        step(v);
        repeat (3) @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and forwarding controller for the 5-stage MIPS pipeline. It generalises the load-use/branch hazard logic in three ways: configurable register-address width, zero-register gating on every comparison, and tracking of one outstanding multi-cycle multiply/divide (MDU) operation. It has a registered tracker FSM and sits beside the datapath, driving the F/D stall enables, the E flush, and the D/E forwarding muxes.

## Interface
Parameters:
- AW, 5, register address width
- MDU_LAT, 4, cycles from MDU issue in E to MDU result write; legal range ≥2
- CW, $clog2(MDU_LAT), width of the MDU countdown

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- rsD, rtD  in  AW  source registers in D
- rsE, rtE  in  AW  source registers in E
- wrE, wrM, wrW  in  AW  destination registers in E/M/W
- regwrE, regwrM, regwrW  in  1  register-write enables in E/M/W
- memtoregE, memtoregM  in  1  load in E/M
- branchD  in  1  branch in D, compared in D
- mduD  in  1  MDU op in D
- mdu_startE  in  1  MDU op issuing from E this cycle
- stallF, stallD  out  1  hold PC / IF-ID
- flushE  out  1  bubble ID-EX
- fwdAD, fwdBD  out  1  forward ALUOutM into the D comparator
- fwdAE, fwdBE  out  2  E operand select: 00 RF, 01 ResultW, 10 ALUOutM
- mdu_busy  out  1  tracker not IDLE
- mdu_done  out  1  one-cycle pulse: MDU result written this cycle
- mdu_dst  out  AW  captured MDU destination

## Operation
- Define hit(x,y) = (x!=0) & (x==y).
- Load-use stall: lwstall = memtoregE & regwrE & (hit(rsD,wrE) | hit(rtD,wrE)).
- Branch stall: brstall = branchD & ((regwrE & (hit(rsD,wrE)|hit(rtD,wrE))) | (memtoregM & (hit(rsD,wrM)|hit(rtD,wrM)))).
- MDU stall: mdustall = mdu_busy & (hit(rsD,mdu_dst) | hit(rtD,mdu_dst) | mduD).
- stallF = stallD = flushE = lwstall | brstall | mdustall.
- fwdAD = regwrM & hit(rsD,wrM); fwdBD is the same with rtD.
- fwdAE = 10 if regwrM & hit(rsE,wrM); otherwise 01 if regwrW & hit(rsE,wrW); otherwise 00. M takes priority over W. fwdBE is the same with rtE.
- Tracker FSM states are IDLE, BUSY and DONE.
  - IDLE: if mdu_startE, capture mdu_dst←wrE, load cnt←MDU_LAT-2, go to BUSY.
  - BUSY: if cnt==0, go to DONE; otherwise decrement cnt.
  - DONE: mdu_done=1. If mdu_startE, capture and go to BUSY (same as from IDLE); otherwise go to IDLE.
- mdu_startE is ignored in BUSY. It cannot legally occur there because mduD stalls in D while busy; the bench asserts this.
- mdu_startE is accepted even when flushE is high in the same cycle, because the E instruction is still valid in that cycle.
- mdu_dst==0: the FSM still runs; there is no dependence stall, but the mduD structural stall still applies.

## Timing
- All stall and forward outputs are combinational from the current inputs plus the registered state, and valid in the same cycle.
- mdu_busy, mdu_done and mdu_dst are derived from registered state only.
- If mdu_startE is high in cycle t, the FSM is BUSY from t+1 and mdu_done=1 in cycle t+MDU_LAT. A dependent instruction in D leaves its stall in cycle t+MDU_LAT+1.
- DONE counts as busy, so a dependent read in the DONE cycle still stalls, and the register file is never read in its write cycle.
- Reset values: state=IDLE, cnt=0, mdu_dst=0. Consequently mdu_busy=0 and mdu_done=0; combinational outputs follow the inputs.
- Reset mid-operation aborts the operation: no mdu_done pulse is produced, and the first cycle after reset is IDLE.

## Structure
- hazard_pkg holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the tracker state enum {IDLE, BUSY, DONE};
  - the hit() function.
- One sub-module, mdu_tracker: the FSM, countdown, and mdu_dst register, exposing busy/done/dst.
- The top level is combinational stall/forward logic plus one mdu_tracker instance.

## Test plan
- Load-use: memtoregE=1, regwrE=1, wrE=8, rsD=8 → stallF=stallD=flushE=1. With wrE=0 and rsD=0 → all 0.
- Branch: branchD=1, memtoregM=1, wrM=3, rtD=3 → stall=1, fwdBD=0. With regwrM=1, memtoregM=0 → stall=0, fwdBD=1.
- Forward priority: rsE=5, wrM=5, wrW=5, regwrM=regwrW=1 → fwdAE=10. With regwrM=0 → 01. With rsE=0 → 00.
- MDU, MDU_LAT=4: mdu_startE at t with wrE=9, rsD=9 held → stall in t+1..t+4, mdu_done only at t+4, stall=0 at t+5. Repeat with mduD instead of rsD → same stall window.
- Back-to-back MDU: mdu_startE in the DONE cycle → BUSY next cycle with the new mdu_dst, and a second done pulse 4 cycles later.
- Reset: rst in BUSY → IDLE next cycle, with no mdu_done pulse and mdu_busy=0.
